dram_fill_requester: RTL and testbench

Cache-side initiator for the DRAM controller's single-pulse line-read interface. Accepts line-miss requests from the cache (fill address, victim upper address, victim dirty flag, victim lane), buffers up to two in a small queue, and issues them one at a time as a `dram_controller_req_read_pulse` with every operand held stable until the matching ack pulse. On ack it captures the 128-bit fill lane and returns it to the cache as a one-cycle `fill_valid` pulse. Sits between the cache miss logic and the DRAM controller, in the `main_clk` domain.

---
 rtl/dram_fill_pkg.sv | 16 +
 rtl/dram_fill_requester_fifo.sv | 46 ++++
 rtl/dram_fill_requester.sv | 126 ++++++++++++
 tb/tb_dram_fill_requester.sv | 305 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dram_fill_pkg.sv
// Shared types for the DRAM fill requester: queued request record and FSM states.
package dram_fill_pkg;
  localparam int LANE_W   = 128;
  localparam int ADDR_W   = 22;
  localparam int UPPER_W  = 13;
  localparam int COMMON_W = 9;

  typedef struct packed {
    logic [ADDR_W-1:0]  addr;
    logic [UPPER_W-1:0] victim_upper;
    logic               dirty;
    logic [LANE_W-1:0]  lane;
  } fill_req_t;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} fill_state_e;
endpackage

// File: rtl/dram_fill_requester_fifo.sv
// Depth 1-2 request queue; a push while full is accepted only alongside a pop.
module dram_req_fifo
  import dram_fill_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic      clk,
  input  logic      rst_n,
  input  logic      push,
  input  logic      pop,
  input  fill_req_t din,
  output logic      full,
  output logic      empty,
  output fill_req_t head
);
  fill_req_t  mem [DEPTH];
  logic       rd_ptr, wr_ptr;
  logic [1:0] count;
  logic       do_push, do_pop;

  function automatic logic bump(input logic p);
    return (DEPTH == 1) ? 1'b0 : ~p;
  endfunction

  assign full    = (count == 2'(DEPTH));
  assign empty   = (count == 2'd0);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
      count  <= 2'd0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= bump(wr_ptr);
      end
      if (do_pop) rd_ptr <= bump(rd_ptr);
      count <= count + 2'(do_push) - 2'(do_pop);
    end
  end
endmodule

// File: rtl/dram_fill_requester.sv
// Cache-side line-fill initiator for the DRAM controller's pulse/ack read interface.
// Optional DRAM_FILL_TIMEOUT_EN: re-pulse the active request after TIMEOUT_CYCLES without ack.
module dram_fill_requester
  import dram_fill_pkg::*;
#(
  parameter int FIFO_DEPTH     = 2,
  parameter int TIMEOUT_CYCLES = 40000
) (
  input  logic                main_clk,
  input  logic                main_rst_n,
  input  logic                miss_valid,
  output logic                miss_ready,
  input  logic [ADDR_W-1:0]   miss_addr,
  input  logic [UPPER_W-1:0]  miss_victim_upper,
  input  logic                miss_victim_dirty,
  input  logic [LANE_W-1:0]   miss_victim_lane,
  output logic                fill_valid,
  output logic [ADDR_W-1:0]   fill_addr,
  output logic [LANE_W-1:0]   fill_lane,
  output logic [UPPER_W-1:0]  addr_req_read_dram_side_dram,
  output logic [UPPER_W-1:0]  addr_req_write_dram_side_dram,
  output logic [COMMON_W-1:0] addr_req_common_side_dram,
  output logic [LANE_W-1:0]   lane_from_cache_to_dram_side_dram,
  output logic                dram_controller_entry_dirty_side_dram,
  output logic                dram_controller_req_read_pulse_side_dram,
  input  logic                dram_controller_ack_read_pulse_side_dram,
  input  logic [LANE_W-1:0]   lane_from_dram_to_cache_side_dram,
  output logic                busy,
  output logic                stray_ack
`ifdef DRAM_FILL_TIMEOUT_EN
  ,
  output logic                timeout_seen
`endif
);
  fill_state_e state, state_nxt;
  fill_req_t   miss_req, head, act_q;
  logic        full, empty, push, pop, ack, to_hit;

  assign ack        = dram_controller_ack_read_pulse_side_dram;
  assign miss_ready = !full;
  assign push       = miss_valid && miss_ready;
  assign miss_req   = '{addr: miss_addr, victim_upper: miss_victim_upper,
                        dirty: miss_victim_dirty, lane: miss_victim_lane};

  dram_req_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (main_clk),
    .rst_n (main_rst_n),
    .push  (push),
    .pop   (pop),
    .din   (miss_req),
    .full  (full),
    .empty (empty),
    .head  (head)
  );

`ifdef DRAM_FILL_TIMEOUT_EN
  logic [15:0] to_cnt;

  assign to_hit = (state == WAIT) && !ack && (to_cnt == 16'(TIMEOUT_CYCLES - 1));

  // ISSUE always precedes WAIT, so clearing there gives a fresh count per (re)issue
  always_ff @(posedge main_clk or negedge main_rst_n) begin
    if (!main_rst_n) begin
      to_cnt       <= '0;
      timeout_seen <= 1'b0;
    end else begin
      if (state == ISSUE)     to_cnt <= '0;
      else if (state == WAIT) to_cnt <= to_cnt + 16'd1;
      if (to_hit) timeout_seen <= 1'b1;
    end
  end
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = ^32'(TIMEOUT_CYCLES);
  assign to_hit             = 1'b0;
`endif

  always_comb begin
    state_nxt = state;
    pop       = 1'b0;
    case (state)
      IDLE: if (!empty) begin
        pop       = 1'b1;
        state_nxt = ISSUE;
      end
      ISSUE: state_nxt = WAIT;
      WAIT: begin
        if (ack)         state_nxt = DONE;
        else if (to_hit) state_nxt = ISSUE;
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge main_clk or negedge main_rst_n) begin
    if (!main_rst_n) begin
      state     <= IDLE;
      act_q     <= '0;
      fill_addr <= '0;
      fill_lane <= '0;
      stray_ack <= 1'b0;
    end else begin
      state <= state_nxt;
      if (pop) act_q <= head;
      if (ack) begin
        if (state == WAIT) begin
          fill_addr <= act_q.addr;
          fill_lane <= lane_from_dram_to_cache_side_dram;
        end else begin
          stray_ack <= 1'b1;
        end
      end
    end
  end

  // operands stay on the bus from ISSUE through the ack; act_q only reloads in IDLE
  assign addr_req_read_dram_side_dram             = act_q.addr[ADDR_W-1:COMMON_W];
  assign addr_req_common_side_dram                = act_q.addr[COMMON_W-1:0];
  assign addr_req_write_dram_side_dram            = act_q.victim_upper;
  assign lane_from_cache_to_dram_side_dram        = act_q.lane;
  assign dram_controller_entry_dirty_side_dram    = act_q.dirty;
  assign dram_controller_req_read_pulse_side_dram = (state == ISSUE);
  assign fill_valid                               = (state == DONE);
  assign busy                                     = !empty || (state != IDLE);
endmodule

// File: tb/tb_dram_fill_requester.sv
// Directed bench for dram_fill_requester: vector table plus multi-cycle sequences.
module tb_dram_fill_requester;
  import dram_fill_pkg::*;

`ifdef DRAM_FILL_TIMEOUT_EN
  localparam int TO = 20;
`else
  localparam int TO = 40000;
`endif

  logic         main_clk = 1'b0;
  logic         main_rst_n = 1'b0;
  logic         miss_valid = 1'b0;
  logic         miss_ready;
  logic [21:0]  miss_addr = '0;
  logic [12:0]  miss_victim_upper = '0;
  logic         miss_victim_dirty = 1'b0;
  logic [127:0] miss_victim_lane = '0;
  logic         fill_valid;
  logic [21:0]  fill_addr;
  logic [127:0] fill_lane;
  logic [12:0]  rd_o, wr_o;
  logic [8:0]   cm_o;
  logic [127:0] vl_o;
  logic         dirty_o, req_o;
  logic         ack = 1'b0;
  logic [127:0] lane_in = '0;
  logic         busy, stray_ack;
`ifdef DRAM_FILL_TIMEOUT_EN
  logic         timeout_seen;
`endif

  always #5 main_clk = ~main_clk;

  dram_fill_requester #(.FIFO_DEPTH(2), .TIMEOUT_CYCLES(TO)) dut (
    .main_clk                                 (main_clk),
    .main_rst_n                               (main_rst_n),
    .miss_valid                               (miss_valid),
    .miss_ready                               (miss_ready),
    .miss_addr                                (miss_addr),
    .miss_victim_upper                        (miss_victim_upper),
    .miss_victim_dirty                        (miss_victim_dirty),
    .miss_victim_lane                         (miss_victim_lane),
    .fill_valid                               (fill_valid),
    .fill_addr                                (fill_addr),
    .fill_lane                                (fill_lane),
    .addr_req_read_dram_side_dram             (rd_o),
    .addr_req_write_dram_side_dram            (wr_o),
    .addr_req_common_side_dram                (cm_o),
    .lane_from_cache_to_dram_side_dram        (vl_o),
    .dram_controller_entry_dirty_side_dram    (dirty_o),
    .dram_controller_req_read_pulse_side_dram (req_o),
    .dram_controller_ack_read_pulse_side_dram (ack),
    .lane_from_dram_to_cache_side_dram        (lane_in),
    .busy                                     (busy),
    .stray_ack                                (stray_ack)
`ifdef DRAM_FILL_TIMEOUT_EN
    ,
    .timeout_seen                             (timeout_seen)
`endif
  );

  int n_vec = 0;
  int n_err = 0;
  int pulse_cnt = 0;

  always @(negedge main_clk) if (req_o) pulse_cnt++;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got running want finished");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic push(input logic [21:0] a, input logic [12:0] vu, input logic d,
                      input logic [127:0] vl);
    int t;
    miss_addr = a; miss_victim_upper = vu; miss_victim_dirty = d; miss_victim_lane = vl;
    miss_valid = 1'b1;
    t = 0;
    while (!miss_ready && t < 200) begin
      @(negedge main_clk);
      t++;
    end
    if (!miss_ready) begin
      chk("push_ready_timeout", 128'(miss_ready), 128'(1));
      miss_valid = 1'b0;
    end else begin
      @(posedge main_clk);
      #1;
    end
  endtask

  // Wait for a pulse, check operands, hold them through a delayed ack, check the fill.
  task automatic serve(input logic [21:0] ea, input logic [12:0] evu, input logic ed,
                       input logic [127:0] evl, input int dly, input logic [127:0] al,
                       output int lat);
    logic [163:0] snap;
    bit ok;
    lat = 0;
    for (int i = 1; i <= 50; i++) begin
      @(negedge main_clk);
      if (req_o) begin
        lat = i;
        break;
      end
    end
    if (lat == 0) begin
      chk("req_pulse_timeout", 128'(req_o), 128'(1));
      return;
    end
    chk("rd_addr", 128'(rd_o), 128'(ea[21:9]));
    chk("common_addr", 128'(cm_o), 128'(ea[8:0]));
    chk("wr_addr", 128'(wr_o), 128'(evu));
    chk("dirty", 128'(dirty_o), 128'(ed));
    chk("victim_lane", vl_o, evl);
    snap = {rd_o, wr_o, cm_o, dirty_o, vl_o};
    ok = 1'b1;
    for (int i = 1; i <= dly; i++) begin
      @(negedge main_clk);
      if (req_o || fill_valid || ({rd_o, wr_o, cm_o, dirty_o, vl_o} !== snap)) ok = 1'b0;
      if (i == dly) begin
        ack = 1'b1;
        lane_in = al;
      end
    end
    chk("held_until_ack", 128'(ok), 128'(1));
    @(negedge main_clk);
    chk("fill_valid", 128'(fill_valid), 128'(1));
    chk("fill_addr", 128'(fill_addr), 128'(ea));
    chk("fill_lane", fill_lane, al);
    ack = 1'b0;
    lane_in = '0;
    @(negedge main_clk);
    chk("fill_pulse_end", 128'(fill_valid), 128'(0));
  endtask

  typedef struct {
    logic [21:0]  addr;
    logic [12:0]  vu;
    logic         dirty;
    logic [127:0] vl;
    int           dly;
    logic [127:0] al;
  } vec_t;

  initial begin
    vec_t tv[4];
    int lat, p0;

    tv[0] = '{22'h2A5F3,  13'h0000, 1'b0, 128'h0, 15,
              128'hDEADBEEF_DEADBEEF_DEADBEEF_DEADBEEF};
    tv[1] = '{22'h3FFFFF, 13'h1ABC, 1'b1,
              128'h0123456789ABCDEF_0123456789ABCDEF, 7,
              128'hCAFEF00D_00000000_11111111_FFFFFFFF};
    tv[2] = '{22'h000200, 13'h0001, 1'b1, 128'h1, 1, 128'h5};
    tv[3] = '{22'h1001FF, 13'h1FFF, 1'b0,
              128'hFFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF, 3, 128'h0};

    // reset state
    repeat (3) @(negedge main_clk);
    chk("rst_req", 128'(req_o), 128'(0));
    chk("rst_fill_valid", 128'(fill_valid), 128'(0));
    chk("rst_fill_addr", 128'(fill_addr), 128'(0));
    chk("rst_fill_lane", fill_lane, 128'(0));
    chk("rst_operands", 128'({rd_o, wr_o, cm_o, dirty_o}), 128'(0));
    chk("rst_busy", 128'(busy), 128'(0));
    chk("rst_ready", 128'(miss_ready), 128'(1));
    chk("rst_stray", 128'(stray_ack), 128'(0));
    main_rst_n = 1'b1;
    @(negedge main_clk);

    // stray ack while idle
    ack = 1'b1;
    lane_in = 128'h77;
    @(negedge main_clk);
    ack = 1'b0;
    chk("stray_set", 128'(stray_ack), 128'(1));
    chk("stray_no_fill0", 128'(fill_valid), 128'(0));
    @(negedge main_clk);
    chk("stray_no_fill1", 128'(fill_valid), 128'(0));
    chk("stray_no_pulse", 128'(pulse_cnt), 128'(0));
    main_rst_n = 1'b0;
    @(negedge main_clk);
    chk("stray_cleared", 128'(stray_ack), 128'(0));
    main_rst_n = 1'b1;
    @(negedge main_clk);

    // single requests from the table
    for (int k = 0; k < 4; k++) begin
      p0 = pulse_cnt;
      push(tv[k].addr, tv[k].vu, tv[k].dirty, tv[k].vl);
      miss_valid = 1'b0;
      serve(tv[k].addr, tv[k].vu, tv[k].dirty, tv[k].vl, tv[k].dly, tv[k].al, lat);
      chk("issue_latency", 128'(lat), 128'(2));
      chk("one_pulse", 128'(pulse_cnt - p0), 128'(1));
    end
    chk("idle_after_table", 128'(busy), 128'(0));

    // back-to-back: three misses against a slow controller
    p0 = pulse_cnt;
    fork
      begin
        push(22'h0AAAAA, 13'h0011, 1'b1, 128'hA);
        push(22'h155555, 13'h0022, 1'b0, 128'hB);
        push(22'h012345, 13'h0033, 1'b1, 128'hC);
        miss_valid = 1'b0;
        chk("b2b_full", 128'(miss_ready), 128'(0));
      end
      begin
        serve(22'h0AAAAA, 13'h0011, 1'b1, 128'hA, 10, 128'hF1, lat);
        chk("b2b_lat_a", 128'(lat), 128'(2));
        serve(22'h155555, 13'h0022, 1'b0, 128'hB, 4, 128'hF2, lat);
        chk("b2b_lat_b", 128'(lat), 128'(1));
        chk("b2b_ready_after_pop", 128'(miss_ready), 128'(1));
        serve(22'h012345, 13'h0033, 1'b1, 128'hC, 2, 128'hF3, lat);
        chk("b2b_lat_c", 128'(lat), 128'(1));
      end
    join
    chk("b2b_three_pulses", 128'(pulse_cnt - p0), 128'(3));
    chk("b2b_idle", 128'(busy), 128'(0));

    // reset while waiting for ack, with a second request still queued
    p0 = pulse_cnt;
    push(22'h111111, 13'h0444, 1'b1, 128'h9);
    push(22'h222222, 13'h0555, 1'b0, 128'h8);
    miss_valid = 1'b0;
    lat = 0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge main_clk);
      if (req_o) begin
        lat = i;
        break;
      end
    end
    chk("midwait_pulse_seen", 128'(lat != 0), 128'(1));
    repeat (3) @(negedge main_clk);
    main_rst_n = 1'b0;
    @(negedge main_clk);
    chk("midwait_rst_busy", 128'(busy), 128'(0));
    chk("midwait_rst_ops", 128'({rd_o, wr_o, cm_o, dirty_o}), 128'(0));
    main_rst_n = 1'b1;
    repeat (5) @(negedge main_clk);
    chk("midwait_queue_flushed", 128'(pulse_cnt - p0), 128'(1));
    ack = 1'b1;
    lane_in = 128'hBAD;
    @(negedge main_clk);
    ack = 1'b0;
    lane_in = '0;
    chk("midwait_stray", 128'(stray_ack), 128'(1));
    @(negedge main_clk);
    chk("midwait_no_fill", 128'(fill_valid), 128'(0));
    push(22'h333333, 13'h0666, 1'b0, 128'h7);
    miss_valid = 1'b0;
    serve(22'h333333, 13'h0666, 1'b0, 128'h7, 5, 128'h600D, lat);

`ifdef DRAM_FILL_TIMEOUT_EN
    // controller never acks: expect a re-pulse every TO+1 cycles
    begin
      logic [163:0] snap;
      int gap;
      push(22'h0F0F0F, 13'h0ABC, 1'b1, 128'h1234);
      miss_valid = 1'b0;
      for (int i = 1; i <= 20; i++) begin
        @(negedge main_clk);
        if (req_o) break;
      end
      chk("to_first_pulse", 128'(req_o), 128'(1));
      chk("to_not_yet", 128'(timeout_seen), 128'(0));
      snap = {rd_o, wr_o, cm_o, dirty_o, vl_o};
      for (int r = 0; r < 2; r++) begin
        gap = 0;
        for (int i = 1; i <= 100; i++) begin
          @(negedge main_clk);
          if (req_o) begin
            gap = i;
            break;
          end
        end
        chk("to_repulse_gap", 128'(gap), 128'(TO + 1));
        chk("to_same_operands", 128'({rd_o, wr_o, cm_o, dirty_o, vl_o}), 128'(snap));
        chk("to_seen", 128'(timeout_seen), 128'(1));
      end
      @(negedge main_clk);
      ack = 1'b1;
      lane_in = 128'h42;
      @(negedge main_clk);
      ack = 1'b0;
      chk("to_fill_valid", 128'(fill_valid), 128'(1));
      chk("to_fill_lane", fill_lane, 128'h42);
    end
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
